// File: rtl/token_bucket_mc.sv
// Multi-channel token-bucket rate limiter with a round-robin grant arbiter.
// Optional per-channel grant counters when TOKEN_BUCKET_MC_STATS_EN is defined.
module token_bucket_mc #(
    parameter  int NCH        = 4,
    parameter  int DEN        = 16,
    parameter  int TOKEN_COST = DEN,
    parameter  int TOK_W      = 16,
    parameter  int RATE_W     = 8,
    parameter  int INIT_FULL  = 1,
    localparam int ID_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          en_i,
    input  logic [NCH*RATE_W-1:0]   rate_i,
    input  logic [NCH*TOK_W-1:0]    cap_i,
    input  logic [NCH-1:0]          req_i,
    output logic [NCH-1:0]          grant_o,
    output logic [ID_W-1:0]         grant_id_o,
    output logic [NCH-1:0]          ready_o,
    input  logic [ID_W-1:0]         stat_sel_i,
    output logic [31:0]             stat_cnt_o
);

    localparam logic [TOK_W:0] COST_X = (TOK_W+1)'(TOKEN_COST);

    logic [TOK_W-1:0] r_tok [NCH];
    logic [NCH-1:0]   r_grant;
    logic [ID_W-1:0]  r_grant_id;
    logic [ID_W-1:0]  r_ptr;

    logic [NCH-1:0]   w_ready;
    logic [NCH-1:0]   w_elig;
    logic             w_found;
    logic [ID_W-1:0]  w_win;
    logic [ID_W-1:0]  w_ptr_next;
    logic [NCH-1:0]   w_grant_next;
    logic [TOK_W-1:0] w_tok_next [NCH];

    always_comb begin
        w_ready = '0;
        w_elig  = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            w_ready[c] = ({1'b0, r_tok[c]} >= COST_X);
            w_elig[c]  = en_i[c] & req_i[c] & w_ready[c];
        end
    end

    // Winner is the eligible channel with the smallest upward distance from r_ptr.
    always_comb begin
        int unsigned v_p;
        int unsigned v_d;
        int unsigned v_best;
        w_found = 1'b0;
        w_win   = '0;
        v_best  = 0;
        v_p     = 32'(r_ptr);
        for (int unsigned c = 0; c < NCH; c++) begin
            v_d = (c >= v_p) ? (c - v_p) : (c + NCH - v_p);
            if (w_elig[c] && (!w_found || v_d < v_best)) begin
                w_found = 1'b1;
                v_best  = v_d;
                w_win   = ID_W'(c);
            end
        end
    end

    assign w_ptr_next = (w_win == ID_W'(NCH - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        logic [TOK_W:0] v_sum;
        logic [TOK_W:0] v_cap;
        logic [TOK_W:0] v_sat;
        w_grant_next = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            w_grant_next[c] = w_found && (w_win == ID_W'(c));
            v_cap = {1'b0, cap_i[c*TOK_W +: TOK_W]};
            v_sum = en_i[c] ? ({1'b0, r_tok[c]} + (TOK_W+1)'(rate_i[c*RATE_W +: RATE_W]))
                            : {1'b0, r_tok[c]};
            v_sat = (v_sum < v_cap) ? v_sum : v_cap;
            // A cap cut in the grant cycle can leave sat below the cost; floor at zero.
            if (w_grant_next[c])
                v_sat = (v_sat >= COST_X) ? (v_sat - COST_X) : '0;
            w_tok_next[c] = TOK_W'(v_sat);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < NCH; c++)
                r_tok[c] <= (INIT_FULL != 0) ? cap_i[c*TOK_W +: TOK_W] : '0;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++)
                r_tok[c] <= w_tok_next[c];
            r_grant    <= w_grant_next;
            r_grant_id <= w_win;
            if (w_found)
                r_ptr <= w_ptr_next;
        end
    end

    assign grant_o    = r_grant;
    assign grant_id_o = r_grant_id;
    assign ready_o    = w_ready;

`ifdef TOKEN_BUCKET_MC_STATS_EN
    logic [31:0] r_cnt [NCH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < NCH; c++)
                r_cnt[c] <= '0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++)
                if (w_grant_next[c] && (r_cnt[c] != '1))
                    r_cnt[c] <= r_cnt[c] + 32'd1;
        end
    end

    always_comb begin
        stat_cnt_o = '0;
        for (int unsigned c = 0; c < NCH; c++)
            if (stat_sel_i == ID_W'(c))
                stat_cnt_o = r_cnt[c];
    end
`else
    logic w_unused_sel;
    assign w_unused_sel = ^stat_sel_i;
    assign stat_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_token_bucket_mc.sv
// Self-checking bench for token_bucket_mc against an integer-arithmetic bucket model.
// Stat checks expect live counters only when TOKEN_BUCKET_MC_STATS_EN is defined.
module tb_token_bucket_mc;

    localparam int NCH  = 4;
    localparam int COST = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCH-1:0]      en_i;
    logic [NCH*8-1:0]    rate_i;
    logic [NCH*16-1:0]   cap_i;
    logic [NCH-1:0]      req_i;
    logic [NCH-1:0]      grant_o;
    logic [1:0]          grant_id_o;
    logic [NCH-1:0]      ready_o;
    logic [1:0]          stat_sel_i;
    logic [31:0]         stat_cnt_o;

    token_bucket_mc #(.NCH(4), .DEN(16), .TOKEN_COST(16), .TOK_W(16), .RATE_W(8), .INIT_FULL(1)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .rate_i(rate_i), .cap_i(cap_i), .req_i(req_i),
        .grant_o(grant_o), .grant_id_o(grant_id_o), .ready_o(ready_o),
        .stat_sel_i(stat_sel_i), .stat_cnt_o(stat_cnt_o)
    );

    always #5 clk = ~clk;

    int          rate [NCH];
    int          cap  [NCH];
    int          m_tok [NCH];
    longint      m_cnt [NCH];
    int          m_ptr;
    logic [3:0]  m_grant;
    int          m_id;
    int          passed = 0;
    int          total  = 0;

    function automatic logic [3:0] m_ready();
        logic [3:0] r = '0;
        for (int c = 0; c < NCH; c++) r[c] = (m_tok[c] >= COST);
        return r;
    endfunction

    function automatic logic [31:0] m_stat(input int sel);
`ifdef TOKEN_BUCKET_MC_STATS_EN
        return 32'(m_cnt[sel]);
`else
        return 32'd0;
`endif
    endfunction

    // Drives inputs, advances the reference model by one edge, then steps the clock.
    task automatic tick(input bit r);
        int win = -1;
        int s;
        rst = r;
        for (int c = 0; c < NCH; c++) begin
            rate_i[c*8 +: 8]   = 8'(rate[c]);
            cap_i[c*16 +: 16]  = 16'(cap[c]);
        end
        if (r) begin
            for (int c = 0; c < NCH; c++) begin
                m_tok[c] = cap[c];
                m_cnt[c] = 0;
            end
            m_ptr = 0; m_grant = '0; m_id = 0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                int c = (m_ptr + k) % NCH;
                if (win < 0 && en_i[c] && req_i[c] && m_tok[c] >= COST) win = c;
            end
            for (int c = 0; c < NCH; c++) begin
                s = en_i[c] ? m_tok[c] + rate[c] : m_tok[c];
                if (s > cap[c]) s = cap[c];
                if (c == win) s = (s >= COST) ? s - COST : 0;
                m_tok[c] = s;
            end
            m_grant = '0;
            if (win >= 0) begin
                m_grant[win] = 1'b1;
                m_id  = win;
                m_ptr = (win + 1) % NCH;
                if (m_cnt[win] < 64'hFFFF_FFFF) m_cnt[win]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setup_all(input int cp, input int rt);
        for (int c = 0; c < NCH; c++) begin
            cap[c] = cp; rate[c] = rt;
        end
        en_i = 4'b1111; req_i = '0; stat_sel_i = '0;
    endtask

    task automatic test_reset();
        setup_all(128, 3);
        tick(1);
        total++; if (grant_o !== 4'b0000) $display("FAIL reset_grant got=%b exp=0000", grant_o); else passed++;
        total++; if (grant_id_o !== 2'd0) $display("FAIL reset_id got=%0d exp=0", grant_id_o); else passed++;
        total++; if (ready_o !== 4'b1111) $display("FAIL reset_ready got=%b exp=1111", ready_o); else passed++;
        for (int s = 0; s < NCH; s++) begin
            stat_sel_i = 2'(s); #1;
            total++; if (stat_cnt_o !== 32'd0) $display("FAIL reset_stat sel=%0d got=%0d exp=0", s, stat_cnt_o); else passed++;
        end
    endtask

    task automatic test_burst();
        setup_all(128, 3);
        tick(1);
        req_i = 4'b0001;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick(0);
            if (cyc <= 8) begin
                total++; if (grant_o !== 4'b0001) $display("FAIL burst_initial cyc=%0d got=%b exp=0001", cyc, grant_o); else passed++;
            end
            total++; if (grant_o !== m_grant) $display("FAIL burst_grant cyc=%0d got=%b exp=%b", cyc, grant_o, m_grant); else passed++;
            total++; if (ready_o !== m_ready()) $display("FAIL burst_ready cyc=%0d got=%b exp=%b", cyc, ready_o, m_ready()); else passed++;
        end
    endtask

    task automatic test_round_robin();
        setup_all(128, 3);
        tick(1);
        req_i = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            tick(0);
            total++; if (grant_id_o !== 2'(i % 4)) $display("FAIL rr_id i=%0d got=%0d exp=%0d", i, grant_id_o, i % 4); else passed++;
            total++; if (grant_o !== m_grant) $display("FAIL rr_grant i=%0d got=%b exp=%b", i, grant_o, m_grant); else passed++;
        end
    endtask

    task automatic test_drain();
        int grants = 0;
        setup_all(128, 3);
        cap[2] = 40; rate[2] = 0;
        tick(1);
        req_i = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            tick(0);
            total++; if (grant_o !== m_grant) $display("FAIL drain_grant i=%0d got=%b exp=%b", i, grant_o, m_grant); else passed++;
            if (grant_o[2]) grants++;
        end
        total++; if (grants != 2) $display("FAIL drain_count got=%0d exp=2", grants); else passed++;
        total++; if (ready_o[2] !== 1'b0) $display("FAIL drain_ready got=%b exp=0", ready_o[2]); else passed++;
    endtask

    task automatic test_cap_change();
        int grants = 0;
        setup_all(128, 0);
        cap[1] = 100;
        tick(1);
        tick(0);
        cap[1] = 20;
        tick(0);
        total++; if (ready_o[1] !== 1'b1) $display("FAIL capchg_ready got=%b exp=1", ready_o[1]); else passed++;
        req_i = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            tick(0);
            if (grant_o[1]) grants++;
        end
        total++; if (grants != 1) $display("FAIL capchg_grants got=%0d exp=1", grants); else passed++;
        total++; if (ready_o[1] !== 1'b0) $display("FAIL capchg_empty got=%b exp=0", ready_o[1]); else passed++;
    endtask

    task automatic test_enable();
        setup_all(128, 3);
        en_i = 4'b0111;
        tick(1);
        req_i = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            tick(0);
            total++; if (grant_o !== 4'b0000) $display("FAIL en_blocked i=%0d got=%b exp=0000", i, grant_o); else passed++;
            total++; if (ready_o[3] !== 1'b1) $display("FAIL en_hold i=%0d got=%b exp=1", i, ready_o[3]); else passed++;
        end
        en_i = 4'b1111;
        tick(0);
        total++; if (grant_o !== 4'b1000) $display("FAIL en_resume got=%b exp=1000", grant_o); else passed++;
    endtask

    task automatic test_mid_reset();
        setup_all(128, 3);
        tick(1);
        req_i = 4'b1111;
        for (int i = 0; i < 3; i++) tick(0);
        tick(1);
        total++; if (grant_o !== 4'b0000) $display("FAIL midrst_grant got=%b exp=0000", grant_o); else passed++;
        for (int s = 0; s < NCH; s++) begin
            stat_sel_i = 2'(s); #1;
            total++; if (stat_cnt_o !== 32'd0) $display("FAIL midrst_stat sel=%0d got=%0d exp=0", s, stat_cnt_o); else passed++;
        end
        tick(0);
        total++; if (grant_o !== 4'b0001) $display("FAIL midrst_ptr got=%b exp=0001", grant_o); else passed++;
    endtask

    task automatic test_stats();
        setup_all(128, 3);
        tick(1);
        req_i = 4'b0001;
        for (int i = 0; i < 5; i++) tick(0);
        req_i = '0;
        tick(0);
        stat_sel_i = 2'd0; #1;
`ifdef TOKEN_BUCKET_MC_STATS_EN
        total++; if (stat_cnt_o !== 32'd5) $display("FAIL stats_ch0 got=%0d exp=5", stat_cnt_o); else passed++;
`else
        total++; if (stat_cnt_o !== 32'd0) $display("FAIL stats_ch0 got=%0d exp=0", stat_cnt_o); else passed++;
`endif
        stat_sel_i = 2'd1; #1;
        total++; if (stat_cnt_o !== 32'd0) $display("FAIL stats_ch1 got=%0d exp=0", stat_cnt_o); else passed++;
    endtask

    task automatic test_random();
        int c;
        int sel;
        setup_all(128, 3);
        tick(1);
        for (int i = 0; i < 600; i++) begin
            en_i  = 4'($urandom) | 4'($urandom);
            req_i = 4'($urandom);
            sel   = int'($urandom_range(0, NCH - 1));
            stat_sel_i = 2'(sel);
            if ($urandom_range(0, 7) == 0) begin
                c = int'($urandom_range(0, NCH - 1));
                rate[c] = int'($urandom_range(0, 255));
                case ($urandom_range(0, 3))
                    0: cap[c] = int'($urandom_range(0, 20));
                    1: cap[c] = int'($urandom_range(0, 300));
                    2: cap[c] = 65535;
                    default: cap[c] = int'($urandom_range(65400, 65535));
                endcase
            end
            tick($urandom_range(0, 63) == 0);
            total++; if (grant_o !== m_grant) $display("FAIL rand_grant i=%0d got=%b exp=%b", i, grant_o, m_grant); else passed++;
            if (m_grant != 0) begin
                total++; if (grant_id_o !== 2'(m_id)) $display("FAIL rand_id i=%0d got=%0d exp=%0d", i, grant_id_o, m_id); else passed++;
            end
            total++; if (ready_o !== m_ready()) $display("FAIL rand_ready i=%0d got=%b exp=%b", i, ready_o, m_ready()); else passed++;
            total++; if (stat_cnt_o !== m_stat(sel)) $display("FAIL rand_stat i=%0d got=%0d exp=%0d", i, stat_cnt_o, m_stat(sel)); else passed++;
        end
    endtask

    initial begin
        rst = 1'b1; en_i = '0; req_i = '0; stat_sel_i = '0; rate_i = '0; cap_i = '0;
        @(posedge clk); #1;
        test_reset();
        test_burst();
        test_round_robin();
        test_drain();
        test_cap_change();
        test_enable();
        test_mid_reset();
        test_stats();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
